// File: rtl/arbiter_pkg.sv
// Shared field layout, route encodings and lane type for the dispatch arbiter.
package arbiter_pkg;

  localparam int INSTR_W   = 32;
  localparam int REG_W     = 5;
  localparam int ROUTE_W   = 2;
  localparam int ROUTE_LSB = 27;
  localparam int RS1_LSB   = 16;
  localparam int RS2_LSB   = 11;
  localparam int IMM_BIT   = 10;
  localparam int RD_LSB    = 0;

  localparam logic [ROUTE_W-1:0] ROUTE_AUTO = 2'b00;
  localparam logic [ROUTE_W-1:0] ROUTE_F1   = 2'b10;
  localparam logic [ROUTE_W-1:0] ROUTE_F2   = 2'b11;

  // Encoding doubles as the index into per-lane arrays.
  typedef enum logic {
    LANE1 = 1'b0,
    LANE2 = 1'b1
  } lane_e;

  function automatic lane_e other_lane(lane_e l);
    return (l == LANE1) ? LANE2 : LANE1;
  endfunction

endpackage

// File: rtl/arbiter_if.sv
// Fetch-to-issue dispatch bus; ARB_FULL_AWARE_EN adds FIFO-full inputs and a stall back to fetch.
interface arbiter_if;
  import arbiter_pkg::*;

  logic               instr_valid;
  logic [INSTR_W-1:0] instr;
  logic [INSTR_W-1:0] instr_out;
  logic               FIFO_1_en;
  logic               FIFO_2_en;
`ifdef ARB_FULL_AWARE_EN
  logic               fifo1_full;
  logic               fifo2_full;
  logic               stall;

  modport master (
    output instr_valid, instr, fifo1_full, fifo2_full,
    input  instr_out, FIFO_1_en, FIFO_2_en, stall
  );
  modport slave (
    input  instr_valid, instr, fifo1_full, fifo2_full,
    output instr_out, FIFO_1_en, FIFO_2_en, stall
  );
`else
  modport master (
    output instr_valid, instr,
    input  instr_out, FIFO_1_en, FIFO_2_en
  );
  modport slave (
    input  instr_valid, instr,
    output instr_out, FIFO_1_en, FIFO_2_en
  );
`endif
endinterface

// File: rtl/arbiter_dep_check.sv
// Combinational dependency hit for one lane: source or destination matches the lane's last rd.
module arbiter_dep_check
  import arbiter_pkg::*;
(
  input  logic [REG_W-1:0] rs1,
  input  logic [REG_W-1:0] rs2,
  input  logic [REG_W-1:0] rd,
  input  logic             imm,
  input  logic [REG_W-1:0] last_rd,
  input  logic             last_rd_vld,
  output logic             hit
);

  // rs2 is an immediate slot when imm is set, so it cannot carry a dependency.
  assign hit = last_rd_vld &&
               ((rs1 == last_rd) || (!imm && (rs2 == last_rd)) || (rd == last_rd));

endmodule

// File: rtl/arbiter.sv
// Dual-lane dispatch arbiter: override or dependency-based routing, one-cycle registered output.
// Optional macro ARB_FULL_AWARE_EN: FIFO-full awareness with stall to fetch.
module arbiter
  import arbiter_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  arbiter_if.slave bus
);

  logic [REG_W-1:0]   rs1, rs2, rd;
  logic               imm;
  logic [ROUTE_W-1:0] route;

  logic [REG_W-1:0]   last_rd_reg [2];
  logic [1:0]         last_rd_vld_reg;
  lane_e              last_lane_reg;
  logic [INSTR_W-1:0] instr_out_reg;
  logic               fifo_1_en_reg;
  logic               fifo_2_en_reg;

  logic [1:0]         hit;
  lane_e              auto_lane;
  lane_e              lane_next;
  logic               dispatch;

  assign rs1   = bus.instr[RS1_LSB +: REG_W];
  assign rs2   = bus.instr[RS2_LSB +: REG_W];
  assign rd    = bus.instr[RD_LSB +: REG_W];
  assign imm   = bus.instr[IMM_BIT];
  assign route = bus.instr[ROUTE_LSB +: ROUTE_W];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dep
      arbiter_dep_check u_dep (
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .imm         (imm),
        .last_rd     (last_rd_reg[gi]),
        .last_rd_vld (last_rd_vld_reg[gi]),
        .hit         (hit[gi])
      );
    end
  endgenerate

`ifdef ARB_FULL_AWARE_EN
  logic [1:0] full;
  logic       blocked;
  assign full      = {bus.fifo2_full, bus.fifo1_full};
  assign bus.stall = bus.instr_valid && blocked;
`endif

  always_comb begin
    case (hit)
      2'b01:   auto_lane = LANE1;
      2'b10:   auto_lane = LANE2;
      2'b11:   auto_lane = last_lane_reg;
      default: auto_lane = other_lane(last_lane_reg);
    endcase
    case (route)
      ROUTE_F1: lane_next = LANE1;
      ROUTE_F2: lane_next = LANE2;
      default:  lane_next = auto_lane;
    endcase
`ifdef ARB_FULL_AWARE_EN
    // Only an independent auto-routed instruction may be redirected around a full lane.
    if (!route[1] && (hit == 2'b00) && full[lane_next] && !full[other_lane(lane_next)])
      lane_next = other_lane(lane_next);
    blocked  = full[lane_next];
    dispatch = bus.instr_valid && !blocked;
`else
    dispatch = bus.instr_valid;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_out_reg   <= '0;
      fifo_1_en_reg   <= 1'b0;
      fifo_2_en_reg   <= 1'b0;
      last_rd_reg[0]  <= '0;
      last_rd_reg[1]  <= '0;
      last_rd_vld_reg <= '0;
      last_lane_reg   <= LANE2;
    end else begin
      fifo_1_en_reg <= dispatch && (lane_next == LANE1);
      fifo_2_en_reg <= dispatch && (lane_next == LANE2);
      if (dispatch) begin
        instr_out_reg              <= bus.instr;
        last_rd_reg[lane_next]     <= rd;
        last_rd_vld_reg[lane_next] <= 1'b1;
        last_lane_reg              <= lane_next;
      end
    end
  end

  assign bus.instr_out = instr_out_reg;
  assign bus.FIFO_1_en = fifo_1_en_reg;
  assign bus.FIFO_2_en = fifo_2_en_reg;

endmodule

// File: tb/tb_arbiter.sv
// Self-checking bench for arbiter: directed vector table, reset corner cases, randomized model compare.
module tb_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  arbiter_if bus();

  arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Reference state: lanes are numbered 1 and 2 as in the routing rules.
  logic [4:0]  m_rd  [1:2];
  bit          m_vld [1:2];
  int          m_last;
  logic [31:0] m_out;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic        f1;
    logic        f2;
    logic [31:0] out;
  } vec_t;

  vec_t vec [15];

  function automatic logic [31:0] mk(logic [1:0] route, logic [4:0] rs1, logic [4:0] rs2,
                                     logic imm, logic [4:0] rd);
    return {3'b000, route, 6'b000000, rs1, rs2, imm, 5'b00000, rd};
  endfunction

  task automatic model_reset();
    m_rd[1] = '0; m_rd[2] = '0;
    m_vld[1] = 0; m_vld[2] = 0;
    m_last = 2;
    m_out = '0;
  endtask

  function automatic int pick_lane(logic [31:0] x);
    bit h [1:2];
    int r = int'(x[28:27]);
    if (r == 2) return 1;
    if (r == 3) return 2;
    for (int k = 1; k <= 2; k++)
      h[k] = m_vld[k] && ((x[20:16] == m_rd[k]) || (!x[10] && x[15:11] == m_rd[k]) ||
                          (x[4:0] == m_rd[k]));
    if (h[1] && h[2]) return m_last;
    if (h[1]) return 1;
    if (h[2]) return 2;
    return 3 - m_last;
  endfunction

  task automatic model_step(input logic v, input logic [31:0] x,
                            output logic f1, output logic f2, output logic [31:0] o);
    int lane;
    f1 = 1'b0; f2 = 1'b0;
    if (v) begin
      lane = pick_lane(x);
      f1 = (lane == 1);
      f2 = (lane == 2);
      m_rd[lane] = x[4:0];
      m_vld[lane] = 1;
      m_last = lane;
      m_out = x;
    end
    o = m_out;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic f1, input logic f2, input logic [31:0] o);
    chk({nm, "_en1"}, 32'(bus.FIFO_1_en), 32'(f1));
    chk({nm, "_en2"}, 32'(bus.FIFO_2_en), 32'(f2));
    chk({nm, "_out"}, bus.instr_out, o);
  endtask

  task automatic apply(input logic v, input logic [31:0] x);
    bus.instr_valid = v;
    bus.instr = x;
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d rst=%b valid=%b instr=%h -> en1=%b en2=%b out=%h",
             txn, rst, v, x, bus.FIFO_1_en, bus.FIFO_2_en, bus.instr_out);
  endtask

  initial begin
    logic        ef1, ef2;
    logic [31:0] eout;
    logic [31:0] rx;
    logic        rv;

`ifdef ARB_FULL_AWARE_EN
    bus.fifo1_full = 1'b0;
    bus.fifo2_full = 1'b0;
`endif
    // Directed sequence: reset exit, overrides, RAW/WAW, imm masking, invalid hold, both-hit, r0.
    vec[0]  = '{1'b1, mk(2'b00, 5'd7, 5'd8, 1'b0, 5'd9),   1'b1, 1'b0, mk(2'b00, 5'd7, 5'd8, 1'b0, 5'd9)};
    vec[1]  = '{1'b1, mk(2'b10, 5'd0, 5'd1, 1'b0, 5'd3),   1'b1, 1'b0, mk(2'b10, 5'd0, 5'd1, 1'b0, 5'd3)};
    vec[2]  = '{1'b1, mk(2'b11, 5'd0, 5'd1, 1'b0, 5'd15),  1'b0, 1'b1, mk(2'b11, 5'd0, 5'd1, 1'b0, 5'd15)};
    vec[3]  = '{1'b1, mk(2'b00, 5'd15, 5'd17, 1'b0, 5'd21), 1'b0, 1'b1, mk(2'b00, 5'd15, 5'd17, 1'b0, 5'd21)};
    vec[4]  = '{1'b1, mk(2'b01, 5'd8, 5'd21, 1'b0, 5'd21), 1'b0, 1'b1, mk(2'b01, 5'd8, 5'd21, 1'b0, 5'd21)};
    vec[5]  = '{1'b1, mk(2'b00, 5'd8, 5'd3, 1'b1, 5'd21),  1'b0, 1'b1, mk(2'b00, 5'd8, 5'd3, 1'b1, 5'd21)};
    vec[6]  = '{1'b1, mk(2'b00, 5'd16, 5'd21, 1'b1, 5'd1), 1'b1, 1'b0, mk(2'b00, 5'd16, 5'd21, 1'b1, 5'd1)};
    vec[7]  = '{1'b0, 32'hDEAD_BEEF,                       1'b0, 1'b0, mk(2'b00, 5'd16, 5'd21, 1'b1, 5'd1)};
    vec[8]  = '{1'b1, mk(2'b11, 5'd0, 5'd0, 1'b1, 5'd4),   1'b0, 1'b1, mk(2'b11, 5'd0, 5'd0, 1'b1, 5'd4)};
    vec[9]  = '{1'b1, mk(2'b10, 5'd0, 5'd0, 1'b1, 5'd3),   1'b1, 1'b0, mk(2'b10, 5'd0, 5'd0, 1'b1, 5'd3)};
    vec[10] = '{1'b1, mk(2'b00, 5'd3, 5'd4, 1'b0, 5'd5),   1'b1, 1'b0, mk(2'b00, 5'd3, 5'd4, 1'b0, 5'd5)};
    vec[11] = '{1'b1, mk(2'b00, 5'd4, 5'd9, 1'b1, 5'd10),  1'b0, 1'b1, mk(2'b00, 5'd4, 5'd9, 1'b1, 5'd10)};
    vec[12] = '{1'b1, mk(2'b00, 5'd0, 5'd0, 1'b1, 5'd0),   1'b1, 1'b0, mk(2'b00, 5'd0, 5'd0, 1'b1, 5'd0)};
    vec[13] = '{1'b1, mk(2'b00, 5'd0, 5'd0, 1'b1, 5'd7),   1'b1, 1'b0, mk(2'b00, 5'd0, 5'd0, 1'b1, 5'd7)};
    vec[14] = '{1'b1, mk(2'b00, 5'd10, 5'd0, 1'b1, 5'd7),  1'b1, 1'b0, mk(2'b00, 5'd10, 5'd0, 1'b1, 5'd7)};

    // Reset held with an all-ones valid instruction on the bus.
    bus.instr_valid = 1'b1;
    bus.instr = 32'hFFFF_FFFF;
    #1;
    check_outs("reset_init", 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) apply(1'b1, 32'hFFFF_FFFF);
    check_outs("reset_hold", 1'b0, 1'b0, 32'h0);
    rst = 1'b0;
    model_reset();

    foreach (vec[i]) begin
      apply(vec[i].valid, vec[i].instr);
      model_step(vec[i].valid, vec[i].instr, ef1, ef2, eout);
      check_outs($sformatf("vec%0d", i), vec[i].f1, vec[i].f2, vec[i].out);
    end

    // Asynchronous reset between edges clears outputs before the next clock.
    apply(1'b1, mk(2'b11, 5'd1, 5'd2, 1'b0, 5'd6));
    check_outs("pre_async", 1'b0, 1'b1, mk(2'b11, 5'd1, 5'd2, 1'b0, 5'd6));
    #2 rst = 1'b1;
    #1;
    check_outs("async_rst", 1'b0, 1'b0, 32'h0);
    apply(1'b1, mk(2'b10, 5'd1, 5'd2, 1'b0, 5'd6));
    check_outs("rst_edge", 1'b0, 1'b0, 32'h0);
    #2 rst = 1'b0;
    model_reset();
    apply(1'b1, mk(2'b00, 5'd9, 5'd9, 1'b0, 5'd9));
    model_step(1'b1, mk(2'b00, 5'd9, 5'd9, 1'b0, 5'd9), ef1, ef2, eout);
    check_outs("post_rst_first", 1'b1, 1'b0, mk(2'b00, 5'd9, 5'd9, 1'b0, 5'd9));

    // Random traffic over a narrow register range so dependencies are frequent.
    for (int i = 0; i < 400; i++) begin
      rv = ($urandom_range(0, 3) != 0);
      rx = $urandom;
      rx[20:16] = 5'($urandom_range(0, 5));
      rx[15:11] = 5'($urandom_range(0, 5));
      rx[4:0]   = 5'($urandom_range(0, 5));
      apply(rv, rx);
      model_step(rv, rx, ef1, ef2, eout);
      check_outs($sformatf("rand%0d", i), ef1, ef2, eout);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
